// File: rtl/image_window_scanner_pkg.sv
// Shared constants and state encoding for the 3x3 window scanner.
//   IMG_W, IMG_H : image dimensions in pixels (fixed at 8x8)
//   DW           : pixel width in bits
//   state_t      : scanner FSM state (IDLE, SCAN, DONE)
package image_window_scanner_pkg;

    localparam int unsigned IMG_W = 8;
    localparam int unsigned IMG_H = 8;
    localparam int unsigned DW    = 8;

    // Window grid is (IMG_H-2) x (IMG_W-2); last row/col index is 5.
    localparam logic [2:0] LAST_R = 3'(IMG_H - 3);
    localparam logic [2:0] LAST_C = 3'(IMG_W - 3);

    typedef logic [1:0] state_t;
    localparam state_t IDLE = 2'd0;
    localparam state_t SCAN = 2'd1;
    localparam state_t DONE = 2'd2;

endpackage

// File: rtl/image_window_scanner_mem.sv
// 64-entry pixel store with a dual-write load port and a 9-tap combinational read.
//   clk      : clock
//   we       : write enable for both load ports
//   adr      : load address for the top half (rows 0-3)
//   data_in1 : pixel written to mem[adr]
//   data_in2 : pixel written to mem[adr+32] (rows 4-7)
//   base     : top-left index of the window (r*8+c)
//   taps     : 3x3 window, taps[0] = top-left, taps[8] = bottom-right
// Contents are deliberately not reset so a reset mid-scan keeps the loaded image.
module img_pixel_mem
    import image_window_scanner_pkg::*;
(
    input  logic                clk,
    input  logic                we,
    input  logic [4:0]          adr,
    input  logic [DW-1:0]       data_in1,
    input  logic [DW-1:0]       data_in2,
    input  logic [5:0]          base,
    output logic [8:0][DW-1:0]  taps
);

    logic [DW-1:0] mem [IMG_W*IMG_H];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[{1'b0, adr}] <= data_in1;
            mem[{1'b1, adr}] <= data_in2;
        end
    end

    // base is at most 45, so base + 18 never exceeds 63.
    for (genvar i = 0; i < 3; i++) begin : g_row
        for (genvar j = 0; j < 3; j++) begin : g_col
            assign taps[i*3+j] = mem[base + 6'(i*IMG_W + j)];
        end
    end

endmodule

// File: rtl/image_window_scanner.sv
// Buffers an 8x8 image loaded two pixels per clock, then on start emits every 3x3
// window (36 in total, row-major order) on nine registered outputs.
//   clk          : clock, rising edge
//   reset        : asynchronous active-low reset
//   start        : 0 = load mode, 1 = request/hold scan
//   ext_mem_adr  : load address 0..31; larger values write nothing
//   data_in1/2   : pixels for mem[adr] and mem[adr+32]
//   complete     : high after the last window, until start drops
//   out1..out9   : current window, out1 top-left, out5 centre, out9 bottom-right
module image_window_scanner
    import image_window_scanner_pkg::*;
(
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [7:0]    ext_mem_adr,
    input  logic [DW-1:0] data_in1,
    input  logic [DW-1:0] data_in2,
    output logic          complete,
    output logic [DW-1:0] out1,
    output logic [DW-1:0] out2,
    output logic [DW-1:0] out3,
    output logic [DW-1:0] out4,
    output logic [DW-1:0] out5,
    output logic [DW-1:0] out6,
    output logic [DW-1:0] out7,
    output logic [DW-1:0] out8,
    output logic [DW-1:0] out9
);

    state_t            state;
    logic [2:0]        r;
    logic [2:0]        c;
    logic [8:0][DW-1:0] win;
    logic [8:0][DW-1:0] taps;
    logic              we;

    assign we = (state == IDLE) && !start && (ext_mem_adr < 8'd32);

    img_pixel_mem u_mem (
        .clk      (clk),
        .we       (we),
        .adr      (ext_mem_adr[4:0]),
        .data_in1 (data_in1),
        .data_in2 (data_in2),
        .base     ({r, c}),
        .taps     (taps)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            r        <= '0;
            c        <= '0;
            win      <= '0;
            complete <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state <= SCAN;
                        r     <= '0;
                        c     <= '0;
                    end
                end
                SCAN: begin
                    win <= taps;
                    if (c == LAST_C) begin
                        c <= '0;
                        if (r == LAST_R) begin
                            r     <= '0;
                            state <= DONE;
                        end else begin
                            r <= r + 3'd1;
                        end
                    end else begin
                        c <= c + 3'd1;
                    end
                end
                DONE: begin
                    // complete follows start; dropping start returns to load mode.
                    if (start) begin
                        complete <= 1'b1;
                    end else begin
                        complete <= 1'b0;
                        state    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign out1 = win[0];
    assign out2 = win[1];
    assign out3 = win[2];
    assign out4 = win[3];
    assign out5 = win[4];
    assign out6 = win[5];
    assign out7 = win[6];
    assign out8 = win[7];
    assign out9 = win[8];

endmodule

// File: tb/tb_image_window_scanner.sv
// Directed self-checking bench for image_window_scanner.
module tb_image_window_scanner;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       start = 1'b0;
    logic [7:0] ext_mem_adr = 8'd0;
    logic [7:0] data_in1 = 8'd0;
    logic [7:0] data_in2 = 8'd0;
    logic       complete;
    logic [7:0] out1, out2, out3, out4, out5, out6, out7, out8, out9;

    int errors = 0;
    int checks = 0;

    logic [7:0] model [64];
    logic [71:0] win;

    assign win = {out1, out2, out3, out4, out5, out6, out7, out8, out9};

    always #5 clk = ~clk;

    image_window_scanner dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .ext_mem_adr (ext_mem_adr),
        .data_in1    (data_in1),
        .data_in2    (data_in2),
        .complete    (complete),
        .out1        (out1),
        .out2        (out2),
        .out3        (out3),
        .out4        (out4),
        .out5        (out5),
        .out6        (out6),
        .out7        (out7),
        .out8        (out8),
        .out9        (out9)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [71:0] obs, input logic [71:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [71:0] exp_win(input int r, input int c);
        logic [71:0] w;
        w = '0;
        for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < 3; j++) begin
                w[71-8*(3*i+j) -: 8] = model[(r+i)*8 + c + j];
            end
        end
        return w;
    endfunction

    // Call right after the edge that sampled start=1 in IDLE.
    task automatic scan_windows(input string tag, input int nwin);
        for (int k = 0; k < nwin; k++) begin
            step();
            check($sformatf("%s_w%0d", tag, k), win, exp_win(k / 6, k % 6));
            if (k == nwin - 1) check($sformatf("%s_cmp_w%0d", tag, k), 72'(complete), 72'd0);
        end
    endtask

    initial begin
        // Test 1: reset state, then idle with start=0.
        #3;
        check("rst_out", win, 72'd0);
        check("rst_cmp", 72'(complete), 72'd0);
        step();
        reset = 1'b1;
        step(); step(); step();
        check("idle_out", win, 72'd0);
        check("idle_cmp", 72'(complete), 72'd0);

        // Test 2: load mem[a]=a, mem[a+32]=a+32.
        for (int a = 0; a < 32; a++) begin
            ext_mem_adr = 8'(a);
            data_in1    = 8'(a);
            data_in2    = 8'(a + 32);
            model[a]      = 8'(a);
            model[a + 32] = 8'(a + 32);
            step();
        end
        check("exp_w0_const", exp_win(0, 0), 72'h00_01_02_08_09_0A_10_11_12);
        start = 1'b1;
        step();  // start sampled
        check("scan_lat", win, 72'd0);

        // Tests 2/3: full scan, complete one clock after the last window.
        scan_windows("scan1", 36);
        check("last_win", win, 72'h2D_2E_2F_35_36_37_3D_3E_3F);
        step();
        check("cmp_rise", 72'(complete), 72'd1);

        // Test 6: complete holds while start=1, outputs hold last window.
        for (int k = 0; k < 5; k++) begin
            step();
            check($sformatf("cmp_hold%0d", k), 72'(complete), 72'd1);
        end
        check("hold_win", win, 72'h2D_2E_2F_35_36_37_3D_3E_3F);
        start = 1'b0;
        step();
        check("cmp_fall", 72'(complete), 72'd0);
        check("idle_hold_win", win, 72'h2D_2E_2F_35_36_37_3D_3E_3F);

        // Test 4: out-of-range address must not write.
        ext_mem_adr = 8'd40;
        data_in1    = 8'hFF;
        data_in2    = 8'hFF;
        step();
        start = 1'b1;
        step();
        scan_windows("scan2", 36);
        step();
        check("cmp_rise2", 72'(complete), 72'd1);
        start = 1'b0;
        step();
        check("cmp_fall2", 72'(complete), 72'd0);

        // Test 5: reset at window 10, memory survives, rescan starts at (0,0).
        start = 1'b1;
        step();
        scan_windows("scan3", 10);
        reset = 1'b0;
        #2;
        check("midrst_out", win, 72'd0);
        check("midrst_cmp", 72'(complete), 72'd0);
        step();
        reset = 1'b1;
        step();  // start still high: IDLE -> SCAN
        scan_windows("scan4", 2);

        // Finish that scan, then drop start and check a fresh load is used.
        for (int k = 2; k < 36; k++) step();
        step();
        check("cmp_rise4", 72'(complete), 72'd1);
        start = 1'b0;
        step();
        check("cmp_fall4", 72'(complete), 72'd0);
        ext_mem_adr = 8'd0;
        data_in1    = 8'hAA;
        data_in2    = 8'h55;
        model[0]    = 8'hAA;
        model[32]   = 8'h55;
        step();
        ext_mem_adr = 8'd9;
        data_in1    = 8'hC3;
        data_in2    = 8'h3C;
        model[9]    = 8'hC3;
        model[41]   = 8'h3C;
        step();
        ext_mem_adr = 8'd255;
        start = 1'b1;
        step();
        scan_windows("scan5", 36);
        check("reload_w0", exp_win(0, 0), 72'hAA_01_02_08_C3_0A_10_11_12);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        errors++;
        $display("FAIL timeout: observed running expected finished");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "timeout");
    end

endmodule
